// File: rtl/adder_collect_pkg.sv
// adder_collect_pkg: shared widths, default sizing and the {cout, sum} result type for the adder result collector.
package adder_collect_pkg;
  localparam int RESULT_W = 9;
  localparam int SUM_W = 8;
  localparam int ADDER_LATENCY_DEF = 4;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic             cout;
    logic [SUM_W-1:0] sum;
  } result_t;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous power-of-two result FIFO with count output; head is read from registered storage, so no fall-through.
module result_fifo import adder_collect_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        push,
  input  logic        pop,
  input  result_t     din,
  output result_t     dout,
  output logic [AW:0] count
);
  result_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge Clk)
    if (Rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rptr];
endmodule

// File: rtl/adder_result_collector.sv
// adder_result_collector: tracks issues into a fixed-latency adder with a token shift register and captures {Cout, Sum} into a credit-protected FIFO.
// Optional macro ADDER_COLLECT_STATS_EN adds capture / carry statistics counters.
module adder_result_collector import adder_collect_pkg::*; #(
  parameter int ADDER_LATENCY = ADDER_LATENCY_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SUM_W-1:0]    Sum,
  input  logic                Cout,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RESULT_W-1:0] res_data,
  output logic [2:0]          inflight
`ifdef ADDER_COLLECT_STATS_EN
  ,
  output logic [15:0]         stat_results,
  output logic [15:0]         stat_carries
`endif
);
  logic [ADDER_LATENCY-1:0] tok;
  logic [$clog2(DEPTH):0] count;
  int n_inflight;
  result_t head;
  logic accept, capture, pop;
  assign accept = in_valid && in_ready;
  assign capture = tok[ADDER_LATENCY-1];
  assign pop = res_valid && res_ready;
  always_ff @(posedge Clk)
    tok <= Rst ? '0 : (tok << 1) | ADDER_LATENCY'(accept);
  always_comb begin
    n_inflight = 0;
    for (int i = 0; i < ADDER_LATENCY; i++) n_inflight += int'(tok[i]);
  end
  // Every accepted op reserves a FIFO slot until popped, so capture can never overflow.
  assign in_ready = int'(count) + n_inflight < DEPTH;
  assign inflight = n_inflight > 7 ? 3'd7 : 3'(n_inflight);
  assign res_valid = count != '0;
  assign res_data = head;
  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk(Clk),
    .Rst(Rst),
    .push(capture),
    .pop(pop),
    .din({Cout, Sum}),
    .dout(head),
    .count(count)
  );
`ifdef ADDER_COLLECT_STATS_EN
  always_ff @(posedge Clk)
    if (Rst) begin
      stat_results <= '0;
      stat_carries <= '0;
    end else if (capture) begin
      stat_results <= stat_results + 16'd1;
      stat_carries <= stat_carries + 16'(Cout);
    end
`endif
endmodule

// File: tb/tb_adder_result_collector.sv
// tb_adder_result_collector: directed bench with a pipelined adder model and an in-order result scoreboard.
module tb_adder_result_collector;
  localparam int L = 4;
  localparam int D = 4;
  logic Clk = 0, Rst = 1, in_valid = 0, res_ready = 0, in_ready, res_valid, Cout, Cin = 0;
  logic [7:0] X = 0, Y = 0, Sum;
  logic [8:0] res_data;
  logic [2:0] inflight;
  logic [8:0] pipe [L];
  logic [8:0] q [$];
  int compared = 0, mismatched = 0, n_acc;
`ifdef ADDER_COLLECT_STATS_EN
  logic [15:0] stat_results, stat_carries;
`endif
  always #5 Clk = ~Clk;
  adder_result_collector #(.ADDER_LATENCY(L), .DEPTH(D)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Sum(Sum),
    .Cout(Cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .inflight(inflight)
`ifdef ADDER_COLLECT_STATS_EN
    ,
    .stat_results(stat_results),
    .stat_carries(stat_carries)
`endif
  );
  always @(posedge Clk) begin
    pipe[0] <= 9'(X) + 9'(Y) + 9'(Cin);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign {Cout, Sum} = pipe[L-1];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  always @(negedge Clk) begin
    if (Rst) q.delete();
    else begin
      if (res_valid) begin
        if (q.size() == 0) check("res_spurious", 32'(q.size()), 1);
        else begin
          check(res_ready ? "res_pop" : "res_hold", 32'(res_data), 32'(q[0]));
          if (res_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(9'(X) + 9'(Y) + 9'(Cin));
    end
  end
  initial begin
    repeat (2) tick;
    Rst = 0;
    check("rst_valid", 32'(res_valid), 0);
    check("rst_data", 32'(res_data), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_ready", 32'(in_ready), 1);
    res_ready = 1;
    X = 6; Y = 7; Cin = 0; in_valid = 1;
    tick;
    in_valid = 0;
    check("lat_inflight", 32'(inflight), 1);
    for (int j = 0; j < L; j++) begin
      check("lat_early", 32'(res_valid), 0);
      tick;
    end
    check("lat_valid", 32'(res_valid), 1);
    check("lat_data", 32'(res_data), 32'h00D);
    repeat (2) tick;
    X = 6; Y = 7; Cin = 0; in_valid = 1;
    tick;
    X = 128; Y = 128; Cin = 0;
    tick;
    X = 192; Y = 128; Cin = 1;
    tick;
    in_valid = 0;
    repeat (L - 2) tick;
    check("b2b_0", 32'(res_data), 32'h00D);
    tick;
    check("b2b_1", 32'(res_data), 32'h100);
    tick;
    check("b2b_2", 32'(res_data), 32'h141);
    repeat (L) tick;
    check("drain_b2b", 32'(q.size()), 0);
    res_ready = 0;
    n_acc = 0;
    for (int c = 0; c < D + L + 2; c++) begin
      X = 8'(c * 37 + 5); Y = 8'(c * 91); Cin = c[0]; in_valid = 1;
      check("credit_ready", 32'(in_ready), 32'(n_acc < D));
      if (in_ready) n_acc++;
      tick;
    end
    check("full_accepts", n_acc, D);
    check("full_held", 32'(q.size()), D);
    check("full_inflight", 32'(inflight), 0);
    check("full_valid", 32'(res_valid), 1);
    res_ready = 1;
    for (int c = 0; c < 16; c++) begin
      X = 8'(c * 53 + 200); Y = 8'(c * 29 + 77); Cin = c[1];
      tick;
      check("credit_bound", 32'(q.size() <= D), 1);
    end
    in_valid = 0;
    repeat (L + D + 2) tick;
    check("drain_all", 32'(q.size()), 0);
    check("drain_valid", 32'(res_valid), 0);
    X = 200; Y = 100; Cin = 1; in_valid = 1;
    tick;
    X = 50; Y = 60; Cin = 0;
    tick;
    in_valid = 0;
    check("pre_rst_inflight", 32'(inflight), 2);
    Rst = 1; in_valid = 1;
    tick;
    Rst = 0; in_valid = 0;
    check("rst_mid_inflight", 32'(inflight), 0);
    for (int j = 0; j < L + 2; j++) begin
      check("rst_no_capture", 32'(res_valid), 0);
      tick;
    end
    check("rst_mid_ready", 32'(in_ready), 1);
    check("rst_mid_inflight2", 32'(inflight), 0);
    X = 0; Y = 0; Cin = 1; in_valid = 1;
    tick;
    X = 128; Y = 160; Cin = 0;
    tick;
    X = 8; Y = 0; Cin = 0;
    tick;
    in_valid = 0;
    repeat (L + 2) tick;
    check("stat_drain", 32'(q.size()), 0);
`ifdef ADDER_COLLECT_STATS_EN
    check("stat_results", 32'(stat_results), 3);
    check("stat_carries", 32'(stat_carries), 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/adder_result_collector.md
ADDER_RESULT_COLLECTOR -- requirements
Module: adder_result_collector

Interface
REQ-001 Parameter ADDER_LATENCY, default 4: Clk edges from operand sample to valid Sum/Cout at pipe_adder_8bit outputs.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; power of two, 2..16.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream has placed X/Y/Cin on the adder inputs this cycle.
REQ-006 in_ready  output  1  collector can accept a new issue this cycle.
REQ-007 Sum  input  8  from pipe_adder_8bit Sum.
REQ-008 Cout  input  1  from pipe_adder_8bit Cout.
REQ-009 res_valid  output  1  res_data holds the oldest captured result.
REQ-010 res_ready  input  1  downstream consumes res_data when high with res_valid.
REQ-011 res_data  output  9  {Cout, Sum} of the oldest result.
REQ-012 inflight  output  3  issued operations not yet captured (0..ADDER_LATENCY, saturates at 7 for display).

Function
REQ-013 Issue handshake: accepted when in_valid && in_ready at a rising edge; in_valid with in_ready low is ignored, not queued.
REQ-014 A token shift register of ADDER_LATENCY bits SHALL shift each edge; bit 0 loads the accept event.
REQ-015 When the token leaves the last stage at edge k+ADDER_LATENCY (accept at edge k), {Cout, Sum} SHALL be written into the FIFO at that edge.
REQ-016 Credit rule: in_ready = (fifo_count + inflight) < DEPTH, combinational from registered state; FIFO therefore never overflows.
REQ-017 Pop occurs when res_valid && res_ready; pop frees a credit visible in in_ready the next cycle.
REQ-018 Simultaneous capture and pop in one edge: count unchanged, both pointers advance; with FIFO empty, captured data appears on res_data the following cycle (no fall-through).
REQ-019 Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-020 Results leave in issue order; back-to-back accepts every cycle SHALL be sustained while credit allows.
REQ-021 res_data SHALL be held stable while res_valid && !res_ready.

Reset
REQ-022 Rst high at an edge clears token register, pointers, count: res_valid=0, res_data=0, inflight=0, in_ready=1 next cycle.
REQ-023 Reset mid-operation discards all in-flight tokens and stored results; adder outputs arriving after reset SHALL NOT be captured.
REQ-024 in_valid during a reset cycle is not accepted.

Configuration
REQ-025 Macro ADDER_COLLECT_STATS_EN defined: adds outputs stat_results[15:0] (captures) and stat_carries[15:0] (captures with Cout=1), both wrap, cleared by Rst.
REQ-026 Macro not defined: those ports and counters do not exist; all other behaviour identical.

Structure
REQ-027 Package adder_collect_pkg holds RESULT_W=9, SUM_W=8, default ADDER_LATENCY and DEPTH constants, and the result typedef {cout, sum}.
REQ-028 One sub-module result_fifo (synchronous, registered output, count output) instantiated once; token register, credit logic and stats live in the top.

Verification (bench instantiates pipe_adder_8bit feeding Sum/Cout, 10 ns Clk)
REQ-029 Issue X=6,Y=7,Cin=0 after reset, res_ready=1 -> res_valid rises exactly ADDER_LATENCY edges after accept, res_data=9'h00D.
REQ-030 Back-to-back issues (6,7,0),(128,128,0),(192,128,1) -> res_data sequence 13/Cout0, 0/Cout1, 65/Cout1 on consecutive cycles.
REQ-031 res_ready=0, issue every cycle -> in_ready falls after DEPTH accepts; exactly DEPTH results held; no loss after res_ready=1.
REQ-032 Full FIFO with in-flight zero, pop and accept same edge -> count stays DEPTH-1+...consistent; credit check never exceeded, order preserved.
REQ-033 Assert Rst with 2 tokens in flight -> no capture afterwards, res_valid=0, inflight=0, in_ready=1.
REQ-034 With ADDER_COLLECT_STATS_EN, issue (0,0,1),(128,160,0),(8,0,0) -> stat_results=3, stat_carries=1.
